// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter: direction encoding and boundary mode.
package counter_pkg;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  typedef enum logic {
    CNT_WRAP = 1'b0,
    CNT_SAT  = 1'b1
  } cnt_mode_e;

endpackage

// File: rtl/cnt_next_logic.sv
// Combinational next-count step: increments/decrements, detects boundary steps,
// picks wrap or saturate target and drives terminal count.
module cnt_next_logic
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] count_i,
  input  logic             addsub_i,
  output logic [WIDTH-1:0] next_o,
  output logic             bnd_o,
  output logic             tc_o
);

  localparam logic [WIDTH:0]   MAX_EXT  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH-1:0] MAX_CNT  = WIDTH'(MAX_VAL);
  localparam bit               SAT_MODE = (SATURATE == int'(CNT_SAT));

  logic [WIDTH:0] cnt_ext;
  logic [WIDTH:0] up_ext;
  logic [WIDTH:0] dn_ext;
  logic           up_hit;
  logic           dn_hit;

  // One extra bit lets the borrow of 0-1 and any overshoot past MAX_VAL show up directly.
  always_comb begin
    cnt_ext = {1'b0, count_i};
    up_ext  = cnt_ext + (WIDTH+1)'(1);
    dn_ext  = cnt_ext - (WIDTH+1)'(1);
    up_hit  = (up_ext > MAX_EXT);
    dn_hit  = dn_ext[WIDTH];
  end

  always_comb begin
    next_o = count_i;
    bnd_o  = 1'b0;
    if (addsub_i == DIR_DOWN) begin
      bnd_o = dn_hit;
      if (dn_hit) begin
        next_o = SAT_MODE ? '0 : MAX_CNT;
      end else begin
        next_o = dn_ext[WIDTH-1:0];
      end
    end else begin
      bnd_o = up_hit;
      if (up_hit) begin
        next_o = SAT_MODE ? MAX_CNT : '0;
      end else begin
        next_o = up_ext[WIDTH-1:0];
      end
    end
  end

  assign tc_o = (addsub_i == DIR_DOWN) ? (count_i == '0) : (count_i == MAX_CNT);

endmodule

// File: rtl/updown_counter_mod.sv
// Loadable up/down counter with programmable modulus, wrap/saturate mode,
// terminal count, one-cycle boundary pulse and sticky overflow.
module updown_counter_mod
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int MAX_VAL  = 2**WIDTH - 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  input  logic             en,
  input  logic             addsub,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] step_cnt;
  logic             step_bnd;
  logic [WIDTH-1:0] load_val;

  cnt_next_logic #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .SATURATE (SATURATE)
  ) u_next (
    .count_i  (count_q),
    .addsub_i (addsub),
    .next_o   (step_cnt),
    .bnd_o    (step_bnd),
    .tc_o     (tc)
  );

  // Out-of-range load values clamp so count never leaves 0..MAX_VAL.
  assign load_val = (D > MAX_CNT) ? MAX_CNT : D;

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = step_cnt;
      wrap_d  = step_bnd;
      ovf_d   = ovf_q | step_bnd;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench: a wrap-mode and a saturate-mode counter (WIDTH=4, MAX_VAL=9) share stimulus.
module tb_updown_counter_mod;

  logic       clk;
  logic       reset, clr, load, en, addsub;
  logic [3:0] d;
  logic [3:0] count_w, count_s;
  logic       tc_w, tc_s, wrap_w, wrap_s, ovf_w, ovf_s;

  int total = 0;
  int bad   = 0;

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .D(d), .en(en), .addsub(addsub),
    .count(count_w), .tc(tc_w), .wrap(wrap_w), .ovf(ovf_w)
  );

  updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .clr(clr), .load(load), .D(d), .en(en), .addsub(addsub),
    .count(count_s), .tc(tc_s), .wrap(wrap_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_w(input string tag, input int c, input logic w, input logic o);
    chk({tag, ".w.count"}, 16'(count_w), 16'(c));
    chk({tag, ".w.wrap"},  16'(wrap_w),  16'(w));
    chk({tag, ".w.ovf"},   16'(ovf_w),   16'(o));
  endtask

  task automatic chk_s(input string tag, input int c, input logic w, input logic o);
    chk({tag, ".s.count"}, 16'(count_s), 16'(c));
    chk({tag, ".s.wrap"},  16'(wrap_s),  16'(w));
    chk({tag, ".s.ovf"},   16'(ovf_s),   16'(o));
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b0; addsub = 1'b0; d = 4'd0;
    step();
    step();
    chk_w("reset", 0, 1'b0, 1'b0);
    chk_s("reset", 0, 1'b0, 1'b0);
    chk("reset.tc", 16'(tc_w), 16'd0);

    // Up count from 0: wrap counter goes 1..9,0,1; saturating one sticks at 9.
    reset = 1'b0; en = 1'b1; addsub = 1'b0;
    for (int i = 1; i <= 11; i++) begin
      step();
      chk_w($sformatf("up%0d", i), i % 10, (i == 10), (i >= 10));
      chk("up.tc", 16'(tc_w), 16'((i % 10) == 9));
      chk_s($sformatf("upsat%0d", i), (i > 9) ? 9 : i, (i >= 10), (i >= 10));
    end

    // Load 0 then count down through the lower boundary.
    en = 1'b0; load = 1'b1; d = 4'd0;
    step();
    chk_w("ld0", 0, 1'b0, 1'b1);
    chk("ld0.tc_up", 16'(tc_w), 16'd0);
    load = 1'b0; en = 1'b1; addsub = 1'b1;
    #1;
    chk("dn.tc_zero", 16'(tc_w), 16'd1);
    step();
    chk_w("dn1", 9, 1'b1, 1'b1);
    chk_s("dn1", 0, 1'b1, 1'b1);
    chk("dn1.tc", 16'(tc_w), 16'd0);
    step();
    chk_w("dn2", 8, 1'b0, 1'b1);
    chk_s("dn2", 0, 1'b1, 1'b1);
    step();
    chk_w("dn3", 7, 1'b0, 1'b1);

    // Clear, then saturate at the top from a load of 8.
    en = 1'b0; clr = 1'b1;
    step();
    chk_w("clr", 0, 1'b0, 1'b0);
    chk_s("clr", 0, 1'b0, 1'b0);
    clr = 1'b0; load = 1'b1; d = 4'd8; addsub = 1'b0;
    step();
    chk_s("ld8", 8, 1'b0, 1'b0);
    load = 1'b0; en = 1'b1;
    step();
    chk_s("sat1", 9, 1'b0, 1'b0);
    chk_w("sat1", 9, 1'b0, 1'b0);
    chk("sat1.tc", 16'(tc_s), 16'd1);
    step();
    chk_s("sat2", 9, 1'b1, 1'b1);
    chk_w("sat2", 0, 1'b1, 1'b1);
    step();
    chk_s("sat3", 9, 1'b1, 1'b1);
    chk_w("sat3", 1, 1'b0, 1'b1);

    // Load wins over en and clamps; clr wins over load.
    load = 1'b1; d = 4'd13;
    step();
    chk_w("clamp", 9, 1'b0, 1'b1);
    chk_s("clamp", 9, 1'b0, 1'b1);
    clr = 1'b1;
    step();
    chk_w("clrld", 0, 1'b0, 1'b0);
    clr = 1'b0;

    // en low holds the count and drops wrap.
    load = 1'b1; d = 4'd5; en = 1'b0;
    step();
    load = 1'b0;
    step();
    chk_w("hold", 5, 1'b0, 1'b0);

    // Reset on the same edge as a boundary step wins.
    load = 1'b1; d = 4'd9;
    step();
    load = 1'b0; en = 1'b1; addsub = 1'b0; reset = 1'b1;
    step();
    chk_w("rstbnd", 0, 1'b0, 1'b0);
    reset = 1'b0; en = 1'b0;

    // Clear on a saturating boundary step also wins.
    load = 1'b1; d = 4'd9;
    step();
    load = 1'b0; en = 1'b1; clr = 1'b1;
    step();
    chk_s("clrbnd", 0, 1'b0, 1'b0);
    clr = 1'b0; en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
